// File: rtl/pe_pkg.sv
// Shared defaults and FSM encoding for the PE sequencing controller.
package pe_pkg;
  localparam int unsigned DEF_FILTER_WIDTH = 8;
  localparam int unsigned DEF_INPUT_WIDTH  = 8;
  localparam int unsigned DEF_PE_OUT_WIDTH = 24;
  localparam int unsigned DEF_NUM_DATA     = 16;
  localparam int unsigned DEF_PE_LAT       = 2;
  localparam int unsigned DEF_CNT_WIDTH    = 16;

  typedef enum logic [1:0] {IDLE, LOAD, FEED, DRAIN} pe_state_e;
endpackage

// File: rtl/pe_result_fifo.sv
// Two-entry result FIFO; a push into a full FIFO succeeds only if the head pops in the same cycle.
module pe_result_fifo #(
  parameter int unsigned WIDTH = 25
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic [1:0]       count
);
  logic [WIDTH-1:0] mem_q [2];
  logic             wr_q;
  logic             rd_q;
  logic [1:0]       cnt_q;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty   = (cnt_q == 2'd0);
    full    = (cnt_q == 2'd2);
    count   = cnt_q;
    head    = mem_q[rd_q];
    do_pop  = pop && !empty;
    do_push = push && (!full || pop);
  end

  // Storage needs no reset: nothing downstream looks at it while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (do_push) wr_q <= ~wr_q;
      if (do_pop)  rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
endmodule

// File: rtl/pe_seq_ctrl.sv
// Sequences filter load and input beats into an external MAC PE and buffers its window results.
module pe_seq_ctrl
  import pe_pkg::*;
#(
  parameter int unsigned FILTER_WIDTH = DEF_FILTER_WIDTH,
  parameter int unsigned INPUT_WIDTH  = DEF_INPUT_WIDTH,
  parameter int unsigned PE_OUT_WIDTH = DEF_PE_OUT_WIDTH,
  parameter int unsigned NUM_DATA     = DEF_NUM_DATA,
  parameter int unsigned PE_LAT       = DEF_PE_LAT,
  parameter int unsigned CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             job_valid,
  output logic                             job_ready,
  input  logic [FILTER_WIDTH*NUM_DATA-1:0] job_A,
  input  logic [CNT_WIDTH-1:0]             job_count,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [INPUT_WIDTH-1:0]           in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [PE_OUT_WIDTH-1:0]          out_data,
  output logic                             out_last,
  output logic                             pe_reset,
  output logic                             pe_Aload,
  output logic                             pe_start,
  output logic [FILTER_WIDTH*NUM_DATA-1:0] pe_A,
  output logic [INPUT_WIDTH-1:0]           pe_B,
  input  logic [PE_OUT_WIDTH-1:0]          pe_Y,
  input  logic                             pe_acc_valid,
  output logic                             busy
);
  localparam int unsigned BEAT_W = (NUM_DATA > 1) ? $clog2(NUM_DATA) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_DATA - 1);

  pe_state_e                      state_q, state_d;
  logic                           rdy_q;
  logic [BEAT_W-1:0]              beat_q;
  logic [CNT_WIDTH-1:0]           win_left_q;
  logic [CNT_WIDTH-1:0]           cap_left_q;
  logic [1:0]                     inflight_q;
  logic [FILTER_WIDTH*NUM_DATA-1:0] a_q;
  logic                           err_q;
  logic [PE_LAT-1:0]              lat_pipe_q;

  logic                           job_take;
  logic                           space_ok;
  logic                           issue;
  logic                           last_beat;
  logic                           pop;
  logic                           overflow;
  logic [PE_OUT_WIDTH:0]          fifo_head;
  logic                           fifo_empty;
  logic                           fifo_full;
  logic [1:0]                     fifo_cnt;

  pe_result_fifo #(
    .WIDTH(PE_OUT_WIDTH + 1)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (pe_acc_valid),
    .push_data({(cap_left_q == CNT_WIDTH'(1)), pe_Y}),
    .pop      (pop),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_cnt)
  );

  always_comb begin
    out_valid = !fifo_empty;
    out_data  = fifo_head[PE_OUT_WIDTH-1:0];
    out_last  = out_valid && fifo_head[PE_OUT_WIDTH];
    pop       = out_valid && out_ready;
    overflow  = pe_acc_valid && fifo_full && !pop;
    // A window may only start if every result already in flight still has a FIFO slot.
    space_ok  = ((2'd2 - fifo_cnt) > inflight_q);
    pe_A      = a_q;
    busy      = (state_q != IDLE);
  end

  always_comb begin
    state_d   = state_q;
    job_ready = 1'b0;
    job_take  = 1'b0;
    in_ready  = 1'b0;
    pe_Aload  = 1'b0;
    pe_start  = 1'b0;
    pe_B      = '0;
    case (state_q)
      IDLE: begin
        job_ready = rdy_q;
        if (job_valid && rdy_q) begin
          job_take = 1'b1;
          if (job_count != '0) state_d = LOAD;
        end
      end
      LOAD: begin
        pe_Aload = 1'b1;
        state_d  = FEED;
      end
      FEED: begin
        in_ready = (beat_q != '0) || space_ok;
        if (in_valid && in_ready) begin
          pe_start = 1'b1;
          pe_B     = in_data;
          if (beat_q == LAST_BEAT && win_left_q == CNT_WIDTH'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (inflight_q == 2'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    pe_reset = !reset_n || job_take;
  end

  always_comb begin
    issue     = pe_start && (beat_q == '0);
    last_beat = pe_start && (beat_q == LAST_BEAT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rdy_q      <= 1'b0;
      beat_q     <= '0;
      win_left_q <= '0;
      cap_left_q <= '0;
      inflight_q <= 2'd0;
      a_q        <= '0;
      err_q      <= 1'b0;
      lat_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      rdy_q      <= 1'b1;
      lat_pipe_q <= (lat_pipe_q << 1) | PE_LAT'(last_beat);
      if (overflow) err_q <= 1'b1;
      if (job_take && job_count != '0) begin
        a_q        <= job_A;
        win_left_q <= job_count;
        cap_left_q <= job_count;
        beat_q     <= '0;
      end
      if (pe_start) begin
        if (beat_q == LAST_BEAT) begin
          beat_q     <= '0;
          win_left_q <= win_left_q - CNT_WIDTH'(1);
        end else begin
          beat_q <= beat_q + BEAT_W'(1);
        end
      end
      if (pe_acc_valid && cap_left_q != '0) cap_left_q <= cap_left_q - CNT_WIDTH'(1);
      case ({issue, pe_acc_valid})
        2'b10:   inflight_q <= inflight_q + 2'd1;
        2'b01:   if (inflight_q != 2'd0) inflight_q <= inflight_q - 2'd1;
        default: ;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n) !err_q);
  a_pe_latency:  assert property (@(posedge clk) disable iff (!reset_n)
                                  pe_acc_valid == lat_pipe_q[PE_LAT-1]);
endmodule

// File: doc/pe_seq_ctrl.md
PE_SEQ_CTRL -- requirements
Module: pe_seq_ctrl

Interface
REQ-001 Parameters SHALL be: FILTER_WIDTH, 8, filter element width; INPUT_WIDTH, 8, input element width; PE_OUT_WIDTH, 24, accumulator width; NUM_DATA, 16, MACs per output window; PE_LAT, 2, cycles from last start=1 cycle to acc_valid; CNT_WIDTH, 16, output-count width.
REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-003 Ports (name dir width meaning) SHALL be: clk in 1 clock; reset_n in 1 async active-low reset.
REQ-004 job_valid in 1, job_ready out 1: job handshake; job_A in FILTER_WIDTH*NUM_DATA filter vector; job_count in CNT_WIDTH number of outputs (0 = none).
REQ-005 in_valid in 1, in_ready out 1, in_data in INPUT_WIDTH: input stream.
REQ-006 out_valid out 1, out_ready in 1, out_data out PE_OUT_WIDTH: result stream; out_last out 1: final result of the job.
REQ-007 pe_reset out 1, pe_Aload out 1, pe_start out 1, pe_A out FILTER_WIDTH*NUM_DATA, pe_B out INPUT_WIDTH: PE drive; pe_Y in PE_OUT_WIDTH, pe_acc_valid in 1: PE result.
REQ-008 busy out 1: high in any state except IDLE.

Function
REQ-009 FSM states SHALL be IDLE, LOAD, FEED, DRAIN.
REQ-010 IDLE: job_ready=1; job_valid&job_ready with job_count>0 -> latch job_A/job_count, go LOAD; with job_count=0 -> accept, stay IDLE, emit nothing.
REQ-011 LOAD: pe_Aload=1 for exactly one cycle with pe_A = latched vector; next FEED.
REQ-012 FEED: in_ready = (space_ok); on in_valid&in_ready, pe_start=1 and pe_B=in_data that same cycle; otherwise pe_start=0 (stall, no MAC).
REQ-013 A beat counter SHALL count 0..NUM_DATA-1, wrapping to 0 after the 16th accepted beat; wrap decrements remaining-window count.
REQ-014 space_ok SHALL be 1 only when result-FIFO free entries exceed windows in flight (issued, result not yet captured); checked at beat 0, held for the window.
REQ-015 After the last beat of the last window, go DRAIN; DRAIN waits until all in-flight results are captured, then IDLE.
REQ-016 pe_acc_valid SHALL push pe_Y into a 2-entry result FIFO same cycle; pe_acc_valid with FIFO full is a protocol error (sticky, checked by assertion, must not occur).
REQ-017 out_valid = FIFO non-empty; out_data = head; pop on out_valid&out_ready; push and pop in same cycle when full SHALL both succeed.
REQ-018 out_last SHALL be 1 on the entry corresponding to the job's final window.
REQ-019 in_ready SHALL be 0 outside FEED; job_ready SHALL be 0 outside IDLE.
REQ-020 Latency: first out_valid SHALL assert PE_LAT+1 cycles after the 16th accepted beat of window 0 (capture register).
REQ-021 pe_reset SHALL be 1 while reset_n=0 and for one cycle in IDLE on job accept; 0 otherwise.

Reset
REQ-022 reset_n=0 SHALL asynchronously force state IDLE, counters 0, FIFO empty, out_valid=0, out_last=0, in_ready=0, job_ready=0, pe_Aload=0, pe_start=0, pe_B=0, busy=0, error flag 0.
REQ-023 Reset mid-job SHALL discard all in-flight results; after release, job_ready=1 on the first clk edge.

Structure
REQ-024 A shared package pe_pkg SHALL hold default widths, NUM_DATA, PE_LAT and the FSM state enum typedef.
REQ-025 The result FIFO SHALL be a separate sub-module pe_result_fifo (depth 2, width PE_OUT_WIDTH+1 incl. last bit); the PE itself is instantiated outside this block.

Verification
REQ-026 Job A=all 0x11, count=1, 16 beats in_data=0x01, out_ready=1 -> one result 0x000110, out_last=1, busy drops 1 cycle after pop.
REQ-027 Count=3, in_data 0x01..0x30 continuous -> three results, out_last only on third, no in_ready bubble while out_ready=1.
REQ-028 out_ready=0 throughout, count=4 -> in_ready deasserts after 2 windows issued; no FIFO overflow; releasing out_ready drains all 4 in order.
REQ-029 in_valid toggled every other cycle -> pe_start follows accepted beats only; results identical to REQ-027.
REQ-030 job_count=0 -> no pe_Aload, no output, job_ready stays 1.
REQ-031 reset_n pulsed low mid-FEED (beat 7 of window 1) -> all outputs at reset values immediately; new job completes correctly.
